upe_tripleadd32: RTL and testbench

UPE_TRIPLEADD32 -- requirements
Module: upe_tripleadd32

---
 rtl/upe_pkg.sv | 8 +
 rtl/upe_add32.sv | 23 ++
 rtl/upe_tripleadd32.sv | 80 ++++++++
 tb/tb_upe_tripleadd32.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/upe_pkg.sv
// Shared constants for the UPE triple-operand adder.
// Holds the default datapath width used by upe_tripleadd32.
package upe_pkg;

    // Default operand and result width in bits.
    localparam int UPE_WIDTH = 32;

endpackage

// File: rtl/upe_add32.sv
// Purely combinational WIDTH-bit adder with carry-in and carry-out.
// Ports: i_a, i_b (operands), i_cin (carry-in), o_sum (wrapped sum), o_cout (carry-out).
module upe_add32
    import upe_pkg::*;
#(
    parameter int WIDTH = UPE_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_full;

    // Extend to WIDTH+1 bits so the top bit captures the carry-out.
    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

    assign o_sum  = w_full[WIDTH-1:0];
    assign o_cout = w_full[WIDTH];

endmodule

// File: rtl/upe_tripleadd32.sv
// Registered three-operand adder: Out = A + B + carryin1 + C + carryin2, one-cycle latency.
// Ports: clk, rst (sync active-high), in_valid, A, B, C, carryin1, carryin2 -> Out, carryout1, carryout2, out_valid.
module upe_tripleadd32
    import upe_pkg::*;
#(
    parameter int WIDTH = UPE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             carryin1,
    input  logic             carryin2,
    output logic [WIDTH-1:0] Out,
    output logic             carryout1,
    output logic             carryout2,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_s1;
    logic             w_c1;
    logic [WIDTH-1:0] w_s2;
    logic             w_c2;

    logic [WIDTH-1:0] r_out;
    logic             r_c1;
    logic             r_c2;
    logic             r_valid;

    // Stage 1: A + B + carryin1.
    upe_add32 #(
        .WIDTH (WIDTH)
    ) u_stage1 (
        .i_a    (A),
        .i_b    (B),
        .i_cin  (carryin1),
        .o_sum  (w_s1),
        .o_cout (w_c1)
    );

    // Stage 2: wrapped stage-1 sum + C + carryin2, same cycle.
    upe_add32 #(
        .WIDTH (WIDTH)
    ) u_stage2 (
        .i_a    (w_s1),
        .i_b    (C),
        .i_cin  (carryin2),
        .o_sum  (w_s2),
        .o_cout (w_c2)
    );

    // Result registers hold when no operation is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_c1  <= 1'b0;
            r_c2  <= 1'b0;
        end else if (in_valid) begin
            r_out <= w_s2;
            r_c1  <= w_c1;
            r_c2  <= w_c2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
        end
    end

    assign Out       = r_out;
    assign carryout1 = r_c1;
    assign carryout2 = r_c2;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_upe_tripleadd32.sv
// Self-checking bench for upe_tripleadd32: directed vectors plus random traffic.
// Expected outputs come from a plain-arithmetic reference model.
module tb_upe_tripleadd32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] C;
    logic        carryin1;
    logic        carryin2;
    logic [31:0] Out;
    logic        carryout1;
    logic        carryout2;
    logic        out_valid;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [31:0] m_out;
    logic        m_c1;
    logic        m_c2;
    logic        m_v;

    upe_tripleadd32 #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .C         (C),
        .carryin1  (carryin1),
        .carryin2  (carryin2),
        .Out       (Out),
        .carryout1 (carryout1),
        .carryout2 (carryout2),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp_v, $time);
        end
    endtask

    // Model one rising edge using whole-number arithmetic.
    task automatic model_edge();
        longint unsigned t1;
        longint unsigned t2;
        if (rst) begin
            m_out = '0;
            m_c1  = 1'b0;
            m_c2  = 1'b0;
            m_v   = 1'b0;
        end else begin
            m_v = in_valid;
            if (in_valid) begin
                t1 = longint'(A) + longint'(B) + longint'(carryin1);
                t2 = (t1 % 64'h1_0000_0000) + longint'(C)
                     + longint'(carryin2);
                m_c1  = (t1 >= 64'h1_0000_0000);
                m_c2  = (t2 >= 64'h1_0000_0000);
                m_out = 32'(t2 % 64'h1_0000_0000);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Out"}, {32'h0, Out}, {32'h0, m_out});
        chk({tag, ".co1"}, {63'h0, carryout1}, {63'h0, m_c1});
        chk({tag, ".co2"}, {63'h0, carryout2}, {63'h0, m_c2});
        chk({tag, ".vld"}, {63'h0, out_valid}, {63'h0, m_v});
    endtask

    // Drive inputs away from the edge, clock once, check #1 later.
    task automatic step(input logic r, input logic v,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic ci1,
                        input logic ci2, input string tag);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        C        = c;
        carryin1 = ci1;
        carryin2 = ci2;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_out = '0;
        m_c1  = 1'b0;
        m_c2  = 1'b0;
        m_v   = 1'b0;
        rst = 1'b1; in_valid = 1'b0;
        A = '0; B = '0; C = '0;
        carryin1 = 1'b0; carryin2 = 1'b0;
        #2;

        step(1, 0, 32'h0, 32'h0, 32'h0, 0, 0, "reset");
        step(1, 0, 32'h0, 32'h0, 32'h0, 0, 0, "reset2");

        // Known-answer vectors with literal expectations
        step(0, 1, 32'h34D51531, 32'hEEEEEEEE, 32'h11111111, 1, 0, "kat1");
        chk("kat1.lit", {30'h0, carryout1, carryout2, Out},
            {30'h0, 1'b1, 1'b0, 32'h34D51531});
        step(0, 1, 32'h0, 32'h0, 32'h0, 0, 0, "zero");
        chk("zero.lit", {30'h0, carryout1, carryout2, Out}, 64'h0);
        step(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, "ones");
        chk("ones.lit", {30'h0, carryout1, carryout2, Out},
            {30'h0, 1'b1, 1'b1, 32'hFFFFFFFF});
        step(0, 1, 32'hFFFFFFFF, 32'h0, 32'h5, 1, 0, "wrap1");
        chk("wrap1.lit", {30'h0, carryout1, carryout2, Out},
            {30'h0, 1'b1, 1'b0, 32'h00000005});

        // Hold for three idle cycles while operands change
        for (int i = 0; i < 3; i++) begin
            step(0, 0, $urandom, $urandom, $urandom, 1'($urandom),
                 1'($urandom), "hold");
            chk("hold.lit", {32'h0, Out}, {32'h0, 32'h00000005});
        end

        // Reset beats in_valid
        step(0, 1, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 1, 1, "pre");
        step(1, 1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h55555555, 1, 1, "rstpri");
        chk("rstpri.lit", {31'h0, out_valid, Out}, 64'h0);

        // First operation right after reset
        step(0, 1, 32'h00000001, 32'h00000002, 32'h00000003, 0, 1, "first");
        chk("first.lit", {32'h0, Out}, {32'h0, 32'h00000007});

        // Random traffic with occasional resets and idle cycles
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
                 $urandom,
                 ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
                 1'($urandom), 1'($urandom), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
